// File: rtl/volume_meter.sv
// rtl/volume_meter.sv - windowed peak detector with sequential 0-9 level quantiser
// Accumulation runs continuously; the FSM only freezes snap and the quantiser.
module volume_meter #(
   parameter int SAMPLE_W = 12,
   parameter int MID      = 2048,
   parameter int WINDOW   = 4000,
   parameter int STEP     = 205
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sample_valid,
   input  logic [SAMPLE_W-1:0] mic_in,
   output logic [3:0]          volume_level,
   output logic                level_valid
);

   localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int THR_W = SAMPLE_W + 1;
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WINDOW - 1);
   localparam logic [SAMPLE_W-1:0] MID_C    = SAMPLE_W'(MID);
   localparam logic [THR_W-1:0]    STEP_C   = THR_W'(STEP);

   typedef enum logic [1:0] {
      ACCUM,
      QUANT,
      UPDATE
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [SAMPLE_W-1:0] mag;
   logic [SAMPLE_W-1:0] peak;
   logic [SAMPLE_W-1:0] peak_max;
   logic [SAMPLE_W-1:0] snap;
   logic [CNT_W-1:0]    cnt;
   logic [THR_W-1:0]    thr;
   logic [3:0]          lvl;
   logic [3:0]          idx;
   logic                win_close;

   assign mag       = (mic_in >= MID_C) ? (mic_in - MID_C) : (MID_C - mic_in);
   assign peak_max  = (mag > peak) ? mag : peak;
   assign win_close = sample_valid && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ACCUM:   if (win_close) state_next = QUANT;
         QUANT:   if (idx == 4'd9) state_next = UPDATE;
         UPDATE:  state_next = ACCUM;
         default: state_next = ACCUM;
      endcase
   end

   // Window accumulator: independent of the FSM so no samples are lost during QUANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak <= '0;
         cnt  <= '0;
      end else if (sample_valid) begin
         if (cnt == CNT_LAST) begin
            peak <= '0;
            cnt  <= '0;
         end else begin
            peak <= peak_max;
            cnt  <= cnt + 1'b1;
         end
      end
   end

   // Quantiser: thr walks STEP, 2*STEP, ... 9*STEP; the last passing idx wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         snap         <= '0;
         lvl          <= '0;
         idx          <= 4'd1;
         thr          <= STEP_C;
         volume_level <= '0;
         level_valid  <= 1'b0;
      end else begin
         level_valid <= 1'b0;
         case (state)
            ACCUM: begin
               if (win_close) begin
                  snap <= peak_max;
                  lvl  <= '0;
                  idx  <= 4'd1;
                  thr  <= STEP_C;
               end
            end
            QUANT: begin
               if ({1'b0, snap} >= thr) lvl <= idx;
               thr <= thr + STEP_C;
               idx <= idx + 4'd1;
            end
            UPDATE: begin
               volume_level <= lvl;
               level_valid  <= 1'b1;
               thr          <= STEP_C;
               idx          <= 4'd1;
            end
            default: begin
               thr <= STEP_C;
            end
         endcase
      end
   end

endmodule
